rx_read_req_arbiter: RTL and testbench
======================================

Name: rx_read_req_arbiter

Overview:
- Shares the single TX-engine read-request path among C_NUM_CHNL rx_port channels. Each channel presents a read request (addr, len, 2-bit sub-tag) from its local requester mux.
- Arbitrates round-robin and allocates a unique PCIe tag from a free pool. Records tag->{channel, sub-tag} for completion routing, and frees the tag on completion-done.
- Sits between the per-channel rx_port instances and tx_engine read-request input / rx_engine completion path.

Parameters:
- C_NUM_CHNL, 4, number of requesting channels (1..12)
- C_TAG_WIDTH, 5, PCIe tag width; pool size C_NUM_TAGS = 2**C_TAG_WIDTH (derived localparam)
- C_CHNL_WIDTH, 4, width of channel index in tag map (>= clog2(C_NUM_CHNL))

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- CHNL_REQ  in  C_NUM_CHNL  per-channel read request, held until acked
- CHNL_LEN  in  10*C_NUM_CHNL  per-channel length in DWs, packed, channel i at [10i+:10]
- CHNL_ADDR  in  64*C_NUM_CHNL  per-channel address, packed
- CHNL_SUBTAG  in  2*C_NUM_CHNL  per-channel rx tag ({sgTx,sgRx} encoding)
- CHNL_REQ_ACK  out  C_NUM_CHNL  one-cycle pulse: channel's request captured
- TXR_REQ  out  1  read request to tx_engine, held until TXR_REQ_ACK
- TXR_REQ_ACK  in  1  tx_engine accepted request
- TXR_TAG  out  C_TAG_WIDTH  allocated PCIe tag
- TXR_ADDR  out  64  request address
- TXR_LEN  out  10  request length
- CPL_DONE  in  1  final completion received for CPL_TAG
- CPL_TAG  in  C_TAG_WIDTH  tag to free
- LKUP_TAG  in  C_TAG_WIDTH  tag map lookup address
- LKUP_CHNL  out  C_CHNL_WIDTH  channel owning LKUP_TAG (registered, 1-cycle latency)
- LKUP_SUBTAG  out  2  sub-tag of LKUP_TAG (registered)
- TAGS_OUT  out  C_TAG_WIDTH+1  count of outstanding tags
- ERR_FREE  out  1  one-cycle pulse: CPL_DONE on a tag not outstanding

Behaviour:
- Reset (RST_N low, async): state IDLE; all tags free; TXR_REQ=0, CHNL_REQ_ACK=0, TXR_TAG/ADDR/LEN=0, LKUP_*=0, TAGS_OUT=0, ERR_FREE=0; RR pointer = C_NUM_CHNL-1 (so channel 0 wins first).
- States: IDLE, ISSUE.
- IDLE: if any CHNL_REQ and a free tag exists, the grant is the first requesting channel searching from pointer+1 with wrap. Next edge: latch addr/len/subtag/tag; write tag map; mark tag busy; pulse CHNL_REQ_ACK[g]; TXR_REQ=1; pointer=g; -> ISSUE. With no free tag, stay IDLE and grant nothing.
- Request-to-TXR_REQ latency: 1 cycle. CHNL_REQ_ACK[g] and the TXR_REQ rise occur on the same edge.
- ISSUE: hold TXR_REQ and all TXR_* stable. On TXR_REQ_ACK high, next edge TXR_REQ=0 -> IDLE. Minimum spacing between grants: 2 cycles.
- Channel must deassert or update CHNL_REQ the cycle after the ack. A request still high in IDLE is treated as new.
- Tag choice: lowest-numbered free tag (priority encoder over free bitmap).
- Free: CPL_DONE with busy CPL_TAG clears it next edge. CPL_DONE with free tag: no state change, ERR_FREE pulses next cycle.
- Simultaneous alloc and free in one cycle: both take effect. TAGS_OUT unchanged. The freed tag is not reusable until the following cycle (allocation uses the pre-edge bitmap).
- TAGS_OUT = popcount of busy, updated incrementally (+1 alloc, -1 free). Never exceeds C_NUM_TAGS.
- Pool full (TAGS_OUT = C_NUM_TAGS): requests stall in IDLE until a free occurs. First grant possible the cycle after the free edge.
- Tag map entries are overwritten only on alloc; a stale lookup of a free tag returns its last owner.
- Reset mid-ISSUE: request is dropped, all tags freed. Channels re-request.

Decomposition:
- Package rx_arb_pkg: state enum (IDLE, ISSUE), tag map entry struct {chnl, subtag}, rr_next_grant function.
- Sub-module rx_tag_pool: free bitmap, lowest-free priority encoder, tag map RAM with registered lookup, outstanding counter, ERR_FREE.

Test Plan:
- Reset then CHNL_REQ[2]=1, addr 0x1000, len 32, subtag 2'b01 -> next cycle CHNL_REQ_ACK=4'b0100, TXR_REQ=1, TXR_TAG=0, TXR_ADDR=0x1000, TXR_LEN=32. TXR_REQ_ACK at +3 -> TXR_REQ low at +4. LKUP_TAG=0 -> LKUP_CHNL=2, LKUP_SUBTAG=01.
- All four CHNL_REQ held high, tx acks immediately -> grant order 0,1,2,3,0, tags 0,1,2,3,4, TAGS_OUT=5.
- C_TAG_WIDTH=2: issue 4 requests, no frees -> 5th request gets no ack, TXR_REQ stays 0. CPL_DONE tag 2 -> grant within 2 cycles with TXR_TAG=2.
- Pool holds tags 0-3 busy. CPL_DONE tag 1 in the same cycle an IDLE grant occurs -> allocated tag 4, TAGS_OUT unchanged. Next request gets tag 1.
- CPL_DONE on a free tag 7 -> ERR_FREE pulses once, TAGS_OUT unchanged.
- RST_N low while in ISSUE with 3 tags busy -> TXR_REQ=0 immediately (async), TAGS_OUT=0. After release, the first request gets tag 0.

Source files
------------

// File: rtl/rx_arb_pkg.sv
// Shared types and helpers for the rx read-request arbiter: FSM states,
// tag-map entry layout and the round-robin grant search.
package rx_arb_pkg;

  localparam int MAX_CHNL = 12;
  localparam int PTR_W    = 4;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_e;

  typedef struct packed {
    logic [PTR_W-1:0] chnl;
    logic [1:0]       subtag;
  } tag_entry_t;

  // First requesting channel after ptr, wrapping at num_chnl; returns ptr if none.
  function automatic logic [PTR_W-1:0] rr_next_grant(
    input logic [MAX_CHNL-1:0] req,
    input logic [PTR_W-1:0]    ptr,
    input int                  num_chnl
  );
    logic [PTR_W-1:0] g;
    logic [PTR_W-1:0] idx;
    logic             found;
    g     = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_CHNL; i++) begin
      idx = PTR_W'((int'(ptr) + i) % num_chnl);
      if (i <= num_chnl && !found && req[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rx_tag_pool.sv
// PCIe tag pool: free bitmap with lowest-free allocation, tag->owner map with
// registered lookup, outstanding-tag counter and bad-free error pulse.
module rx_tag_pool
  import rx_arb_pkg::*;
#(
  parameter int C_TAG_WIDTH  = 5,
  parameter int C_CHNL_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc_i,
  input  logic [PTR_W-1:0]        alloc_chnl_i,
  input  logic [1:0]              alloc_subtag_i,
  output logic [C_TAG_WIDTH-1:0]  alloc_tag_o,
  output logic                    avail_o,
  input  logic                    cpl_done_i,
  input  logic [C_TAG_WIDTH-1:0]  cpl_tag_i,
  input  logic [C_TAG_WIDTH-1:0]  lkup_tag_i,
  output logic [C_CHNL_WIDTH-1:0] lkup_chnl_o,
  output logic [1:0]              lkup_subtag_o,
  output logic [C_TAG_WIDTH:0]    tags_out_o,
  output logic                    err_free_o
);

  localparam int NUM_TAGS = 2 ** C_TAG_WIDTH;
  localparam int CW       = C_TAG_WIDTH + 1;

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q;
  tag_entry_t          map_q [NUM_TAGS];
  tag_entry_t          lkup_q;
  logic                do_free;

  // Allocation sees only the pre-edge bitmap, so a tag freed this cycle
  // cannot be handed out until the next one.
  always_comb begin
    alloc_tag_o = '0;
    avail_o     = 1'b0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (!busy_q[i] && !avail_o) begin
        alloc_tag_o = C_TAG_WIDTH'(i);
        avail_o     = 1'b1;
      end
    end
    do_free = cpl_done_i && busy_q[cpl_tag_i];
    busy_d  = busy_q;
    if (alloc_i) busy_d[alloc_tag_o] = 1'b1;
    if (do_free) busy_d[cpl_tag_i] = 1'b0;
    cnt_d = cnt_q;
    if (alloc_i && !do_free) cnt_d = cnt_q + CW'(1);
    if (!alloc_i && do_free) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      lkup_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) map_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= cpl_done_i && !busy_q[cpl_tag_i];
      lkup_q <= map_q[lkup_tag_i];
      if (alloc_i) map_q[alloc_tag_o] <= '{chnl: alloc_chnl_i, subtag: alloc_subtag_i};
    end
  end

  assign lkup_chnl_o   = C_CHNL_WIDTH'(lkup_q.chnl);
  assign lkup_subtag_o = lkup_q.subtag;
  assign tags_out_o    = cnt_q;
  assign err_free_o    = err_q;

endmodule

// File: rtl/rx_read_req_arbiter.sv
// Round-robin arbiter sharing the tx_engine read-request path among rx_port
// channels, tagging each request from the shared PCIe tag pool.
module rx_read_req_arbiter
  import rx_arb_pkg::*;
#(
  parameter int C_NUM_CHNL   = 4,
  parameter int C_TAG_WIDTH  = 5,
  parameter int C_CHNL_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [C_NUM_CHNL-1:0]    CHNL_REQ,
  input  logic [10*C_NUM_CHNL-1:0] CHNL_LEN,
  input  logic [64*C_NUM_CHNL-1:0] CHNL_ADDR,
  input  logic [2*C_NUM_CHNL-1:0]  CHNL_SUBTAG,
  output logic [C_NUM_CHNL-1:0]    CHNL_REQ_ACK,
  output logic                     TXR_REQ,
  input  logic                     TXR_REQ_ACK,
  output logic [C_TAG_WIDTH-1:0]   TXR_TAG,
  output logic [63:0]              TXR_ADDR,
  output logic [9:0]               TXR_LEN,
  input  logic                     CPL_DONE,
  input  logic [C_TAG_WIDTH-1:0]   CPL_TAG,
  input  logic [C_TAG_WIDTH-1:0]   LKUP_TAG,
  output logic [C_CHNL_WIDTH-1:0]  LKUP_CHNL,
  output logic [1:0]               LKUP_SUBTAG,
  output logic [C_TAG_WIDTH:0]     TAGS_OUT,
  output logic                     ERR_FREE
);

  // Handshakes: CHNL_REQ is held until its one-cycle CHNL_REQ_ACK pulse;
  // TXR_REQ with TXR_* stays stable until sampled together with TXR_REQ_ACK.
  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q;
  logic [C_TAG_WIDTH-1:0] tag_q;
  logic [63:0]            addr_q;
  logic [9:0]             len_q;
  logic [C_NUM_CHNL-1:0]  ack_q, ack_d;

  logic                   tag_avail;
  logic [C_TAG_WIDTH-1:0] alloc_tag;
  logic                   do_grant;
  logic [PTR_W-1:0]       grant_idx;
  logic [63:0]            sel_addr;
  logic [9:0]             sel_len;
  logic [1:0]             sel_subtag;

  always_comb begin
    grant_idx  = rr_next_grant(MAX_CHNL'(CHNL_REQ), ptr_q, C_NUM_CHNL);
    do_grant   = (state_q == IDLE) && (|CHNL_REQ) && tag_avail;
    sel_addr   = '0;
    sel_len    = '0;
    sel_subtag = '0;
    ack_d      = '0;
    for (int i = 0; i < C_NUM_CHNL; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_addr   = CHNL_ADDR[64*i +: 64];
        sel_len    = CHNL_LEN[10*i +: 10];
        sel_subtag = CHNL_SUBTAG[2*i +: 2];
        ack_d[i]   = do_grant;
      end
    end
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_grant) state_d = ISSUE;
      ISSUE:   if (TXR_REQ_ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(C_NUM_CHNL - 1);
      tag_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      if (do_grant) begin
        ptr_q  <= grant_idx;
        tag_q  <= alloc_tag;
        addr_q <= sel_addr;
        len_q  <= sel_len;
      end
    end
  end

  rx_tag_pool #(
    .C_TAG_WIDTH  (C_TAG_WIDTH),
    .C_CHNL_WIDTH (C_CHNL_WIDTH)
  ) u_pool (
    .clk_i          (CLK),
    .rst_ni         (RST_N),
    .alloc_i        (do_grant),
    .alloc_chnl_i   (grant_idx),
    .alloc_subtag_i (sel_subtag),
    .alloc_tag_o    (alloc_tag),
    .avail_o        (tag_avail),
    .cpl_done_i     (CPL_DONE),
    .cpl_tag_i      (CPL_TAG),
    .lkup_tag_i     (LKUP_TAG),
    .lkup_chnl_o    (LKUP_CHNL),
    .lkup_subtag_o  (LKUP_SUBTAG),
    .tags_out_o     (TAGS_OUT),
    .err_free_o     (ERR_FREE)
  );

  assign CHNL_REQ_ACK = ack_q;
  assign TXR_REQ      = (state_q == ISSUE);
  assign TXR_TAG      = tag_q;
  assign TXR_ADDR     = addr_q;
  assign TXR_LEN      = len_q;

endmodule

// File: tb/tb_rx_read_req_arbiter.sv
// Directed bench for rx_read_req_arbiter: reset, single grant, round-robin,
// alloc/free overlap, bad free, pool exhaustion and reset mid-issue.
module tb_rx_read_req_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   chnl_req;
  logic [39:0]  chnl_len;
  logic [255:0] chnl_addr;
  logic [7:0]   chnl_subtag;
  logic [3:0]   chnl_req_ack;
  logic         txr_req;
  logic         txr_req_ack;
  logic [4:0]   txr_tag;
  logic [63:0]  txr_addr;
  logic [9:0]   txr_len;
  logic         cpl_done;
  logic [4:0]   cpl_tag;
  logic [4:0]   lkup_tag;
  logic [3:0]   lkup_chnl;
  logic [1:0]   lkup_subtag;
  logic [5:0]   tags_out;
  logic         err_free;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_read_req_arbiter #(
    .C_NUM_CHNL   (4),
    .C_TAG_WIDTH  (5),
    .C_CHNL_WIDTH (4)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .CHNL_REQ     (chnl_req),
    .CHNL_LEN     (chnl_len),
    .CHNL_ADDR    (chnl_addr),
    .CHNL_SUBTAG  (chnl_subtag),
    .CHNL_REQ_ACK (chnl_req_ack),
    .TXR_REQ      (txr_req),
    .TXR_REQ_ACK  (txr_req_ack),
    .TXR_TAG      (txr_tag),
    .TXR_ADDR     (txr_addr),
    .TXR_LEN      (txr_len),
    .CPL_DONE     (cpl_done),
    .CPL_TAG      (cpl_tag),
    .LKUP_TAG     (lkup_tag),
    .LKUP_CHNL    (lkup_chnl),
    .LKUP_SUBTAG  (lkup_subtag),
    .TAGS_OUT     (tags_out),
    .ERR_FREE     (err_free)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the active edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chnl_req    = '0;
    txr_req_ack = 1'b0;
    cpl_done    = 1'b0;
    cpl_tag     = '0;
    lkup_tag    = '0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Single-channel request with immediate tx accept; tag and channel data checked.
  task automatic do_req(input int ch, input int exp_tag);
    logic [3:0] oh;
    oh          = 4'b0001 << ch;
    chnl_req    = oh;
    txr_req_ack = 1'b1;
    tick();
    chk("req_ack", 64'(chnl_req_ack), 64'(oh));
    chk("req_txr_req", 64'(txr_req), 64'(1));
    chk("req_tag", 64'(txr_tag), 64'(exp_tag));
    chk("req_addr", txr_addr, 64'h2000 + 64'(ch) * 64'h100);
    chnl_req = '0;
    tick();
    chk("req_txr_drop", 64'(txr_req), 64'(0));
    txr_req_ack = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b1;
    chnl_req    = '0;
    chnl_len    = '0;
    chnl_addr   = '0;
    chnl_subtag = '0;
    txr_req_ack = 1'b0;
    cpl_done    = 1'b0;
    cpl_tag     = '0;
    lkup_tag    = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_txr_req", 64'(txr_req), 64'(0));
    chk("rst_ack", 64'(chnl_req_ack), 64'(0));
    chk("rst_tags_out", 64'(tags_out), 64'(0));
    chk("rst_txr_tag", 64'(txr_tag), 64'(0));
    chk("rst_txr_addr", txr_addr, 64'(0));
    chk("rst_err_free", 64'(err_free), 64'(0));
    chk("rst_lkup_chnl", 64'(lkup_chnl), 64'(0));
    do_reset();

    // Single request on channel 2.
    chnl_addr[2*64 +: 64] = 64'h1000;
    chnl_len[2*10 +: 10]  = 10'd32;
    chnl_subtag[2*2 +: 2] = 2'b01;
    chnl_req              = 4'b0100;
    tick();
    chk("t1_ack", 64'(chnl_req_ack), 64'(4'b0100));
    chk("t1_txr_req", 64'(txr_req), 64'(1));
    chk("t1_tag", 64'(txr_tag), 64'(0));
    chk("t1_addr", txr_addr, 64'h1000);
    chk("t1_len", 64'(txr_len), 64'(32));
    chk("t1_tags_out", 64'(tags_out), 64'(1));
    chnl_req = '0;
    tick();
    chk("t1_ack_pulse", 64'(chnl_req_ack), 64'(0));
    chk("t1_hold1", 64'(txr_req), 64'(1));
    tick();
    chk("t1_hold2", 64'(txr_req), 64'(1));
    chk("t1_hold_addr", txr_addr, 64'h1000);
    txr_req_ack = 1'b1;
    tick();
    chk("t1_drop", 64'(txr_req), 64'(0));
    txr_req_ack = 1'b0;
    lkup_tag    = 5'd0;
    tick();
    chk("t1_lkup_chnl", 64'(lkup_chnl), 64'(2));
    chk("t1_lkup_sub", 64'(lkup_subtag), 64'(1));

    // All four channels held high: round-robin from channel 0 after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chnl_addr[i*64 +: 64]  = 64'h2000 + 64'(i) * 64'h100;
      chnl_len[i*10 +: 10]   = 10'(10 + i);
      chnl_subtag[i*2 +: 2]  = 2'(i);
    end
    chnl_req    = 4'b1111;
    txr_req_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_ack", 64'(chnl_req_ack), 64'(4'b0001 << (k % 4)));
      chk("rr_tag", 64'(txr_tag), 64'(k));
      chk("rr_len", 64'(txr_len), 64'(10 + (k % 4)));
      tick();
      chk("rr_gap", 64'(txr_req), 64'(0));
      if (k == 4) chnl_req = '0;
    end
    txr_req_ack = 1'b0;
    chk("rr_tags_out", 64'(tags_out), 64'(5));
    lkup_tag = 5'd3;
    tick();
    chk("rr_lkup_chnl", 64'(lkup_chnl), 64'(3));
    chk("rr_lkup_sub", 64'(lkup_subtag), 64'(3));

    // Free tag 1 on the same edge as a grant: new tag is 5, count unchanged.
    chnl_req    = 4'b0010;
    txr_req_ack = 1'b1;
    cpl_done    = 1'b1;
    cpl_tag     = 5'd1;
    tick();
    chk("ov_ack", 64'(chnl_req_ack), 64'(4'b0010));
    chk("ov_tag", 64'(txr_tag), 64'(5));
    chk("ov_tags_out", 64'(tags_out), 64'(5));
    chnl_req = '0;
    cpl_done = 1'b0;
    tick();
    txr_req_ack = 1'b0;
    do_req(2, 1);
    chk("ov_tags_out2", 64'(tags_out), 64'(6));

    // Completion for a tag that is not outstanding.
    cpl_done = 1'b1;
    cpl_tag  = 5'd7;
    tick();
    chk("err_pulse", 64'(err_free), 64'(1));
    chk("err_tags_out", 64'(tags_out), 64'(6));
    cpl_done = 1'b0;
    tick();
    chk("err_once", 64'(err_free), 64'(0));
    chk("err_tags_out2", 64'(tags_out), 64'(6));
    cpl_done = 1'b1;
    cpl_tag  = 5'd0;
    tick();
    chk("free_no_err", 64'(err_free), 64'(0));
    chk("free_tags_out", 64'(tags_out), 64'(5));
    cpl_done = 1'b0;

    // Fill the pool: busy is {1..5}, so tag 0 then 6..31 go out in order.
    do_req(0, 0);
    for (int t = 6; t < 32; t++) do_req(t % 4, t);
    chk("full_tags_out", 64'(tags_out), 64'(32));
    chnl_req = 4'b0001;
    tick();
    chk("full_stall_ack", 64'(chnl_req_ack), 64'(0));
    chk("full_stall_req", 64'(txr_req), 64'(0));
    tick();
    chk("full_stall_req2", 64'(txr_req), 64'(0));
    cpl_done = 1'b1;
    cpl_tag  = 5'd2;
    tick();
    chk("full_free_edge", 64'(txr_req), 64'(0));
    chk("full_free_cnt", 64'(tags_out), 64'(31));
    cpl_done = 1'b0;
    tick();
    chk("full_regrant", 64'(txr_req), 64'(1));
    chk("full_regrant_tag", 64'(txr_tag), 64'(2));
    chk("full_regrant_ack", 64'(chnl_req_ack), 64'(4'b0001));
    chk("full_regrant_cnt", 64'(tags_out), 64'(32));
    chnl_req    = '0;
    txr_req_ack = 1'b1;
    tick();
    chk("full_drop", 64'(txr_req), 64'(0));
    txr_req_ack = 1'b0;

    // Reset while a request is in ISSUE with 3 tags outstanding.
    do_reset();
    do_req(0, 0);
    do_req(1, 1);
    chnl_req = 4'b0100;
    tick();
    chnl_req = '0;
    chk("mid_issue", 64'(txr_req), 64'(1));
    chk("mid_tags_out", 64'(tags_out), 64'(3));
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(txr_req), 64'(0));
    chk("mid_rst_cnt", 64'(tags_out), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_req(3, 0);
    chk("post_rst_cnt", 64'(tags_out), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
